key_debounce_multi: RTL and testbench

Parametrised multi-key debouncer and press-event generator. Synchronises N raw push-button inputs and samples them on a single-cycle tick enable derived from clk_in; there is no derived clock. Each key is reported as a stable level plus one-cycle press, release, long-press and auto-repeat pulses. Sits between the board buttons and the audio control logic (volume, mode, mute).

---
 rtl/key_debounce_pkg.sv | 15 +
 rtl/key_debounce_channel.sv | 111 +++++++++++
 rtl/key_debounce_multi.sv | 73 +++++++
 tb/tb_key_debounce_multi.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// Shared types and helpers for the multi-key debouncer.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } key_state_e;

  // Bits needed to hold 0..max_val; never less than one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// One key: debounce counter, hold/repeat FSM and single-cycle event pulses.
module key_debounce_channel
  import key_debounce_pkg::*;
#(
  parameter int STABLE_TICKS = 20,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 100
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic tick,
  input  logic sample,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long,
  output logic key_repeat
);

  localparam int SW = cnt_w(STABLE_TICKS);
  localparam int HW = cnt_w(LONG_TICKS);
  localparam int RW = cnt_w(REPEAT_TICKS);
  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_TICKS - 1);
  localparam logic [HW-1:0] HOLD_MAX    = HW'(LONG_TICKS);
  localparam logic [RW-1:0] RPT_MAX     = RW'(REPEAT_TICKS);

  key_state_e    state;
  logic [SW-1:0] db_cnt;
  logic [HW-1:0] hold_cnt;
  logic [RW-1:0] rpt_cnt;

  logic [HW-1:0] hold_nxt;
  logic [RW-1:0] rpt_nxt;
  logic          differ;
  logic          accept;

  assign hold_nxt = hold_cnt + 1'b1;
  assign rpt_nxt  = rpt_cnt + 1'b1;
  assign differ   = (sample != key_level);
  assign accept   = differ && (db_cnt == STABLE_LAST);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      db_cnt      <= '0;
      hold_cnt    <= '0;
      rpt_cnt     <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
      key_repeat  <= 1'b0;
    end else begin
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
      key_repeat  <= 1'b0;
      if (tick) begin
        // Debounce: a run of STABLE_TICKS differing samples flips the level.
        if (!differ) begin
          db_cnt <= '0;
        end else if (accept) begin
          db_cnt      <= '0;
          key_level   <= sample;
          key_press   <= sample;
          key_release <= !sample;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end

        // An accepted edge overrides hold/repeat progress on the same tick.
        if (accept && sample) begin
          state    <= PRESSED;
          hold_cnt <= '0;
          rpt_cnt  <= '0;
        end else if (accept && !sample) begin
          state    <= IDLE;
          hold_cnt <= '0;
          rpt_cnt  <= '0;
        end else begin
          case (state)
            PRESSED: begin
              hold_cnt <= hold_nxt;
              if (hold_nxt == HOLD_MAX) begin
                key_long <= 1'b1;
                rpt_cnt  <= '0;
                state    <= LONG;
              end
            end
            LONG: begin
              // hold_cnt stays at LONG_TICKS here, i.e. saturated.
              if (REPEAT_TICKS != 0) begin
                if (rpt_nxt == RPT_MAX) begin
                  key_repeat <= 1'b1;
                  rpt_cnt    <= '0;
                end else begin
                  rpt_cnt <= rpt_nxt;
                end
              end
            end
            default: begin
              hold_cnt <= '0;
              rpt_cnt  <= '0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/key_debounce_multi.sv
// Multi-key debouncer: shared sample tick, per-key 2-FF sync, per-key channel.
module key_debounce_multi
  import key_debounce_pkg::*;
#(
  parameter int NUM_KEYS     = 3,
  parameter int CLK_HZ       = 50_000_000,
  parameter int TICK_HZ      = 1_000,
  parameter int STABLE_TICKS = 20,
  parameter int LONG_TICKS   = 1_000,
  parameter int REPEAT_TICKS = 100,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                clk_in,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long,
  output logic [NUM_KEYS-1:0] key_repeat
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int TW  = cnt_w(DIV - 1);
  localparam logic [TW-1:0]       DIV_LAST = TW'(DIV - 1);
  localparam logic [NUM_KEYS-1:0] IDLE_PIN = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [TW-1:0]       tick_cnt;
  logic                tick;
  logic [NUM_KEYS-1:0] sync1;
  logic [NUM_KEYS-1:0] sync2;
  logic [NUM_KEYS-1:0] key_sample;

  assign tick = (tick_cnt == DIV_LAST);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n)    tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  // Sync flops reset to the released-pin level so reset never looks like a press.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= IDLE_PIN;
      sync2 <= IDLE_PIN;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
    end
  end

  assign key_sample = (ACTIVE_LOW != 0) ? ~sync2 : sync2;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    key_debounce_channel #(
      .STABLE_TICKS (STABLE_TICKS),
      .LONG_TICKS   (LONG_TICKS),
      .REPEAT_TICKS (REPEAT_TICKS)
    ) u_ch (
      .clk_in      (clk_in),
      .rst_n       (rst_n),
      .tick        (tick),
      .sample      (key_sample[g]),
      .key_level   (key_level[g]),
      .key_press   (key_press[g]),
      .key_release (key_release[g]),
      .key_long    (key_long[g]),
      .key_repeat  (key_repeat[g])
    );
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Scoreboard bench: expected events (key, kind, cycle) queued at stimulus time.
module tb_key_debounce_multi;

  localparam int NK = 3;
  localparam int K_PRESS = 0, K_REL = 1, K_LONG = 2, K_RPT = 3;

  logic          clk_in = 1'b0;
  logic          rst_n  = 1'b0;
  logic [NK-1:0] key_in = '1;
  logic [NK-1:0] key_level, key_press, key_release, key_long, key_repeat;

  key_debounce_multi #(
    .NUM_KEYS(NK), .CLK_HZ(1000), .TICK_HZ(100), .STABLE_TICKS(3),
    .LONG_TICKS(10), .REPEAT_TICKS(4), .ACTIVE_LOW(1)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .key_in(key_in), .key_level(key_level),
    .key_press(key_press), .key_release(key_release), .key_long(key_long),
    .key_repeat(key_repeat)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {int key; int kind; int cyc;} ev_t;
  ev_t sbq[$];
  int  total = 0, bad = 0;
  int  cyc;

  // Clock edges since reset release; tick edges fall on multiples of 10.
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack(input int kind, input int key, input int c);
    return (32'(kind) << 28) | (32'(key) << 24) | (32'(c) & 32'h00FF_FFFF);
  endfunction

  // First tick edge that samples a pin changed just after edge c (2 sync flops).
  function automatic int ft(input int c);
    return ((c + 12) / 10) * 10;
  endfunction

  task automatic exp_ev(input int key, input int kind, input int c);
    ev_t e;
    e.key = key; e.kind = kind; e.cyc = c;
    sbq.push_back(e);
  endtask

  task automatic wait_until(input int t);
    int g;
    g = 0;
    while (cyc < t && g < 5000) begin
      @(negedge clk_in);
      g++;
    end
    if (g >= 5000) chk("timeout", 32'(cyc), 32'(t));
  endtask

  task automatic align10();
    @(negedge clk_in);
    while (cyc % 10 != 0) @(negedge clk_in);
  endtask

  always @(negedge clk_in) begin
    if (rst_n) begin
      for (int k = 0; k < NK; k++) begin
        for (int t = 0; t < 4; t++) begin : per_kind
          logic hit;
          ev_t  e;
          case (t)
            K_PRESS: hit = key_press[k];
            K_REL:   hit = key_release[k];
            K_LONG:  hit = key_long[k];
            default: hit = key_repeat[k];
          endcase
          if (hit) begin
            if (sbq.size() == 0) begin
              chk("unexpected_pulse", pack(t, k, cyc), 32'hFFFF_FFFF);
            end else begin
              e = sbq.pop_front();
              chk("event", pack(t, k, cyc), pack(e.kind, e.key, e.cyc));
            end
          end
        end
      end
    end
  end

  initial begin
    int c, p;
    // Reset and idle
    repeat (3) @(negedge clk_in);
    chk("rst_level", 32'(key_level), 32'd0);
    rst_n = 1'b1;
    wait_until(100);
    chk("idle_level", 32'(key_level), 32'd0);
    chk("idle_pulses", 32'(key_press | key_release | key_long | key_repeat), 32'd0);

    // Key 0 held through long press and two repeats
    key_in[0] = 1'b0;
    c = cyc;
    p = ft(c) + 20;
    exp_ev(0, K_PRESS, p);
    exp_ev(0, K_LONG, p + 100);
    exp_ev(0, K_RPT, p + 140);
    exp_ev(0, K_RPT, p + 180);
    wait_until(p + 5);
    chk("hold_level0", 32'(key_level), 32'd1);
    wait_until(p + 185);
    key_in[0] = 1'b1;
    c = ft(cyc) + 20;
    exp_ev(0, K_REL, c);
    wait_until(c + 5);
    chk("rel_level0", 32'(key_level), 32'd0);

    // Key 1 bounces every tick, then settles pressed
    align10();
    c = cyc;
    for (int i = 0; i < 20; i++) begin
      key_in[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (10) @(negedge clk_in);
    end
    chk("bounce_level1", 32'(key_level), 32'd0);
    key_in[1] = 1'b0;
    exp_ev(1, K_PRESS, c + 230);
    wait_until(c + 240);
    chk("settle_level1", 32'(key_level), 32'd2);
    key_in[1] = 1'b1;
    c = ft(cyc) + 20;
    exp_ev(1, K_REL, c);
    wait_until(c + 10);

    // Key 2 short press: no long event
    align10();
    c = cyc;
    key_in[2] = 1'b0;
    exp_ev(2, K_PRESS, c + 30);
    repeat (50) @(negedge clk_in);
    key_in[2] = 1'b1;
    exp_ev(2, K_REL, c + 80);
    wait_until(c + 200);
    chk("short_level2", 32'(key_level), 32'd0);

    // Keys 0 and 2 together, key 0 into LONG, then reset while held
    @(negedge clk_in);
    key_in[0] = 1'b0;
    key_in[2] = 1'b0;
    p = ft(cyc) + 20;
    exp_ev(0, K_PRESS, p);
    exp_ev(2, K_PRESS, p);
    wait_until(p + 15);
    key_in[2] = 1'b1;
    exp_ev(2, K_REL, p + 40);
    exp_ev(0, K_LONG, p + 100);
    wait_until(p + 105);
    chk("long_level0", 32'(key_level), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_level", 32'(key_level), 32'd0);
    chk("mid_rst_pulses", 32'(key_press | key_release | key_long | key_repeat), 32'd0);
    repeat (3) @(negedge clk_in);
    rst_n = 1'b1;
    exp_ev(0, K_PRESS, 30);
    wait_until(40);
    chk("repress_level0", 32'(key_level), 32'd1);
    key_in[0] = 1'b1;
    c = ft(cyc) + 20;
    exp_ev(0, K_REL, c);
    wait_until(c + 20);

    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
